// File: rtl/div_seq_restoring.sv
// Unsigned sequential restoring divider, one quotient bit per cycle.
// Valid/ready on both sides; one division in flight at a time.
module div_seq_restoring #(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         Clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [N-1:0]  q_reg, q_next;
    logic [N-1:0]  d_reg, d_next;
    logic [N:0]    r_reg, r_next;
    logic [N-1:0]  quotient_reg, quotient_next;
    logic [N-1:0]  remainder_reg, remainder_next;
    logic          dbz_reg, dbz_next;

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [N:0]    trial;
    logic          trial_ge;
    logic [N:0]    r_step;
    logic [N-1:0]  q_step;

    always_comb begin
        trial    = {r_reg[N-1:0], q_reg[N-1]};
        trial_ge = (trial >= {1'b0, d_reg});
        r_step   = trial_ge ? (trial - {1'b0, d_reg}) : trial;
        q_step   = {q_reg[N-2:0], trial_ge};
    end

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            r_reg         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            q_reg         <= q_next;
            d_reg         <= d_next;
            r_reg         <= r_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        q_next         = q_reg;
        d_next         = d_reg;
        r_next         = r_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    q_next     = dividend;
                    d_next     = divisor;
                    r_next     = '0;
                    count_next = '0;
                    if (divisor == '0) begin
                        // Zero divisor skips iteration entirely.
                        state_next     = DONE;
                        quotient_next  = '1;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                q_next     = q_step;
                r_next     = r_step;
                count_next = count_reg + CW'(1);
                if (count_reg == CW'(N - 1)) begin
                    state_next     = DONE;
                    quotient_next  = q_step;
                    remainder_next = r_step[N-1:0];
                    dbz_next       = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_seq_restoring.sv
// Self-checking bench for div_seq_restoring: directed table, corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_div_seq_restoring;

    localparam int N = 8;

    logic         Clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int passes = 0;

    always #5 Clk = ~Clk;

    div_seq_restoring #(.N(N)) dut (
        .Clk         (Clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else passes++;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    function automatic logic [N-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return N'(1);
            default: return N'($urandom);
        endcase
    endfunction

    // Runs one division. lat counts edges after the accept edge until out_valid is seen.
    // proto_ok covers: bounded waits, stable outputs under stall, and clean return to IDLE.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit rnd,
                         output logic [N-1:0] q, output logic [N-1:0] r, output logic z,
                         output int lat, output bit proto_ok);
        int guard;
        int stall;
        proto_ok = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) proto_ok = 1'b0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (rnd) begin
                dividend = N'($urandom);
                divisor  = N'($urandom);
            end
            tick();
            lat++;
        end
        if (!out_valid) proto_ok = 1'b0;
        q = quotient;
        r = remainder;
        z = div_by_zero;
        stall = rnd ? $urandom_range(0, 3) : 0;
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            tick();
            if (!out_valid || in_ready || quotient !== q || remainder !== r || div_by_zero !== z)
                proto_ok = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        if (out_valid || !in_ready) proto_ok = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input bit rnd);
        logic [N-1:0] q, r, eq, er;
        logic         z, ez;
        int           lat;
        bit           ok;
        do_op(a, b, rnd, q, r, z, lat, ok);
        model(a, b, eq, er, ez);
        $display("%s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b, q, r, z, lat);
        if (rnd) begin
            checks++;
            if (q !== eq || r !== er || z !== ez || lat != ((b == 0) ? 0 : N) || !ok)
                $display("FAIL %s %0d/%0d: got q=%0d r=%0d z=%0d lat=%0d proto=%0d, expected q=%0d r=%0d z=%0d lat=%0d proto=1",
                         tag, a, b, q, r, z, lat, ok, eq, er, ez, (b == 0) ? 0 : N);
            else passes++;
        end else begin
            check({tag, " quotient"}, int'(q), int'(eq));
            check({tag, " remainder"}, int'(r), int'(er));
            check({tag, " div_by_zero"}, int'(z), int'(ez));
            check({tag, " latency"}, lat, (b == 0) ? 0 : N);
            check({tag, " protocol"}, int'(ok), 1);
        end
    endtask

    initial begin
        vec_t         vecs[11];
        logic [N-1:0] q, r;
        logic         z;
        int           lat;
        bit           ok;

        vecs[0]  = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   z: 1'b0};
        vecs[1]  = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
        vecs[2]  = '{a: 8'd0,   b: 8'd9,   q: 8'd0,   r: 8'd0,   z: 1'b0};
        vecs[3]  = '{a: 8'd3,   b: 8'd200, q: 8'd0,   r: 8'd3,   z: 1'b0};
        vecs[4]  = '{a: 8'd200, b: 8'd200, q: 8'd1,   r: 8'd0,   z: 1'b0};
        vecs[5]  = '{a: 8'd5,   b: 8'd0,   q: 8'hFF,  r: 8'd5,   z: 1'b1};
        vecs[6]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0};
        vecs[7]  = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254, z: 1'b0};
        vecs[8]  = '{a: 8'd255, b: 8'd0,   q: 8'hFF,  r: 8'd255, z: 1'b1};
        vecs[9]  = '{a: 8'd0,   b: 8'd0,   q: 8'hFF,  r: 8'd0,   z: 1'b1};
        vecs[10] = '{a: 8'd128, b: 8'd3,   q: 8'd42,  r: 8'd2,   z: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset div_by_zero", int'(div_by_zero), 0);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, 1'b0, q, r, z, lat, ok);
            $display("vec%0d: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", i, vecs[i].a, vecs[i].b, q, r, z, lat);
            check($sformatf("vec%0d quotient", i), int'(q), int'(vecs[i].q));
            check($sformatf("vec%0d remainder", i), int'(r), int'(vecs[i].r));
            check($sformatf("vec%0d div_by_zero", i), int'(z), int'(vecs[i].z));
            check($sformatf("vec%0d latency", i), lat, vecs[i].z ? 0 : N);
            check($sformatf("vec%0d protocol", i), int'(ok), 1);
        end

        // Backpressure: result must sit still while out_ready is low, and new input is refused.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 8'd100;
        divisor   = 8'd7;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("bp latency", lat, N);
        in_valid = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        for (int s = 0; s < 5; s++) begin
            tick();
            $display("bp stall %0d: q=%0d r=%0d dbz=%0d out_valid=%0d in_ready=%0d",
                     s, quotient, remainder, div_by_zero, out_valid, in_ready);
            check("bp out_valid", int'(out_valid), 1);
            check("bp in_ready", int'(in_ready), 0);
            check("bp quotient", int'(quotient), 14);
            check("bp remainder", int'(remainder), 2);
            check("bp div_by_zero", int'(div_by_zero), 0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp release in_ready", int'(in_ready), 1);
        check("bp release out_valid", int'(out_valid), 0);

        // Reset during iteration 3 discards the in-flight division.
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("midcalc busy in_ready", int'(in_ready), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("midcalc reset: in_ready=%0d out_valid=%0d q=%0d r=%0d dbz=%0d",
                 in_ready, out_valid, quotient, remainder, div_by_zero);
        check("midcalc reset in_ready", int'(in_ready), 1);
        check("midcalc reset out_valid", int'(out_valid), 0);
        check("midcalc reset quotient", int'(quotient), 0);
        check("midcalc reset remainder", int'(remainder), 0);
        check("midcalc reset div_by_zero", int'(div_by_zero), 0);
        run_and_check("post-reset", 8'd100, 8'd7, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            run_and_check($sformatf("rnd%0d", n), rand_op(), rand_op(), 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
